// File: rtl/bcd_serial_add_ctrl.sv
// bcd_serial_add_ctrl
//   Digit-serial BCD adder controller. A start request captures two packed BCD
//   operands and a carry-in. The operands then pass one digit per clock,
//   least significant digit first, through a single-digit BCD add/correct
//   stage. This is the serial counterpart of a parallel multi-digit BCD adder.
//
// Ports
//   clk    rising-edge clock
//   rst    synchronous, active-high reset
//   start  operation request, sampled only while ready=1
//   A, B   packed BCD operands (4*DIGITS bits), digit0 = [3:0]
//   cin    carry into digit0
//   ready  high in IDLE or DONE: a start on this cycle is accepted
//   busy   high in RUN
//   done   one-cycle pulse: S, cout and err are valid
//   S      packed BCD sum, held until the next accepted start
//   cout   carry out of the most significant digit
//   err    at least one captured A/B digit was greater than 9
//
// Handshake: the request is taken on a rising edge where ready && start.
// There is no backpressure on the result side. done is high for exactly one
// cycle, DIGITS cycles after the cycle that contained the accepting edge.
// S, cout and err keep their values until the next accept or reset.
// A start seen while busy=1 is dropped, not queued.
module bcd_serial_add_ctrl #(
  parameter int DIGITS = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [4*DIGITS-1:0] A,
  input  logic [4*DIGITS-1:0] B,
  input  logic                cin,
  output logic                ready,
  output logic                busy,
  output logic                done,
  output logic [4*DIGITS-1:0] S,
  output logic                cout,
  output logic                err
);

  localparam int W  = 4 * DIGITS;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic            carry_q, carry_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    s_q, s_d;
  logic            cout_q, cout_d;
  logic            err_q, err_d;
  logic            done_q, done_d;

  // Single-digit stage signals
  logic [3:0]      a_dig;
  logic [3:0]      b_dig;
  logic [4:0]      t_sum;
  logic [3:0]      res_dig;
  logic            carry_n;
  logic            in_err;

  // Digit select for the current index, and the BCD add/correct step.
  // Invalid digits use the same rule; the result wraps mod 16.
  always_comb begin
    a_dig = 4'd0;
    b_dig = 4'd0;
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_q == IW'(i)) begin
        a_dig = a_q[i*4 +: 4];
        b_dig = b_q[i*4 +: 4];
      end
    end
    t_sum = {1'b0, a_dig} + {1'b0, b_dig} + {4'd0, carry_q};
    if (t_sum > 5'd9) begin
      res_dig = t_sum[3:0] + 4'd6;
      carry_n = 1'b1;
    end else begin
      res_dig = t_sum[3:0];
      carry_n = 1'b0;
    end
  end

  // Flag any non-decimal digit on the incoming operands.
  // This is only used at the accept edge.
  always_comb begin
    in_err = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((A[i*4 +: 4] > 4'd9) || (B[i*4 +: 4] > 4'd9)) begin
        in_err = 1'b1;
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    cout_d  = cout_q;
    err_d   = err_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = A;
          b_d     = B;
          carry_d = cin;
          idx_d   = '0;
          s_d     = '0;
          cout_d  = 1'b0;
          err_d   = in_err;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end

      ST_RUN: begin
        for (int i = 0; i < DIGITS; i++) begin
          if (idx_q == IW'(i)) begin
            s_d[i*4 +: 4] = res_dig;
          end
        end
        carry_d = carry_n;
        idx_d   = idx_q + 1'b1;
        if (idx_q == IW'(DIGITS - 1)) begin
          cout_d  = carry_n;
          done_d  = 1'b1;
          state_d = ST_DONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  assign ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign busy  = (state_q == ST_RUN);
  assign done  = done_q;
  assign S     = s_q;
  assign cout  = cout_q;
  assign err   = err_q;

endmodule

// File: tb/tb_bcd_serial_add_ctrl.sv
// tb_bcd_serial_add_ctrl
//   Directed plus random bench for bcd_serial_add_ctrl.
//   It drives a DIGITS=3 instance and a DIGITS=1 instance.
//   Expected {cout, err, S} words are queued when an operation is started.
//   They are compared when the matching done pulse appears.
module tb_bcd_serial_add_ctrl;

  logic        clk;
  logic        rst;

  // DIGITS=3 instance
  logic        start;
  logic [11:0] A, B;
  logic        cin;
  logic        ready, busy, done, cout, err;
  logic [11:0] S;

  // DIGITS=1 instance
  logic        start1;
  logic [3:0]  A1, B1;
  logic        cin1;
  logic        ready1, busy1, done1, cout1, err1;
  logic [3:0]  S1;

  logic [13:0] exp_q[$];
  logic [5:0]  exp1_q[$];

  int n_cmp;
  int n_err;

  bcd_serial_add_ctrl #(.DIGITS(3)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B), .cin(cin),
    .ready(ready), .busy(busy), .done(done), .S(S), .cout(cout), .err(err)
  );

  bcd_serial_add_ctrl #(.DIGITS(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .A(A1), .B(B1), .cin(cin1),
    .ready(ready1), .busy(busy1), .done(done1), .S(S1), .cout(cout1), .err(err1)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Decimal reference for valid operands: convert to integers and add.
  // Then split the sum back into digits.
  function automatic logic [13:0] model3(input logic [11:0] a, input logic [11:0] b, input logic c);
    int av, bv, sum;
    logic [11:0] s;
    logic co;
    av = 0;
    bv = 0;
    for (int i = 2; i >= 0; i--) begin
      av = av * 10 + int'(a[i*4 +: 4]);
      bv = bv * 10 + int'(b[i*4 +: 4]);
    end
    sum = av + bv + int'(c);
    co  = (sum >= 1000);
    sum = sum % 1000;
    for (int i = 0; i < 3; i++) begin
      s[i*4 +: 4] = 4'(sum % 10);
      sum = sum / 10;
    end
    return {co, 1'b0, s};
  endfunction

  // Driver tasks; both are called on a falling edge
  task automatic do_start(input logic [11:0] a, input logic [11:0] b, input logic c);
    A = a;
    B = b;
    cin = c;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int lat, input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_latency"}, n, lat);
  endtask

  // Scoreboard monitors
  always @(negedge clk) begin
    if (done === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("done_without_request", {31'd0, done}, 32'd0);
      end else begin
        check("result3", {18'd0, cout, err, S}, {18'd0, exp_q.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (done1 === 1'b1) begin
      if (exp1_q.size() == 0) begin
        check("done1_without_request", {31'd0, done1}, 32'd0);
      end else begin
        check("result1", {26'd0, cout1, err1, S1}, {26'd0, exp1_q.pop_front()});
      end
    end
  end

  initial begin
    logic [11:0] ra, rb;
    logic        rc;
    n_cmp = 0;
    n_err = 0;
    rst = 1'b1;
    start = 1'b0;
    A = '0;
    B = '0;
    cin = 1'b0;
    start1 = 1'b0;
    A1 = '0;
    B1 = '0;
    cin1 = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("rst_ready", {31'd0, ready}, 32'd1);
    check("rst_busy",  {31'd0, busy},  32'd0);
    check("rst_done",  {31'd0, done},  32'd0);
    check("rst_S",     {20'd0, S},     32'd0);
    check("rst_cout",  {31'd0, cout},  32'd0);
    check("rst_err",   {31'd0, err},   32'd0);

    // 000 + 000 + 1
    exp_q.push_back({1'b0, 1'b0, 12'h001});
    do_start(12'h000, 12'h000, 1'b1);
    check("run_busy",  {31'd0, busy},  32'd1);
    check("run_ready", {31'd0, ready}, 32'd0);
    wait_done(3, "t1");
    @(negedge clk);
    check("t1_done_pulse", {31'd0, done},  32'd0);
    check("t1_idle_ready", {31'd0, ready}, 32'd1);
    check("t1_S_held",     {20'd0, S},     32'h001);

    // Full ripple carry
    exp_q.push_back({1'b1, 1'b0, 12'h999});
    do_start(12'h999, 12'h999, 1'b1);
    wait_done(3, "t2");
    @(negedge clk);

    exp_q.push_back({1'b1, 1'b0, 12'h517});
    do_start(12'h682, 12'h835, 1'b0);
    wait_done(3, "t3a");
    @(negedge clk);
    exp_q.push_back({1'b0, 1'b0, 12'h520});
    do_start(12'h451, 12'h069, 1'b0);
    wait_done(3, "t3b");
    @(negedge clk);

    // Back-to-back: second start issued during the first done cycle
    exp_q.push_back({1'b1, 1'b0, 12'h004});
    do_start(12'h387, 12'h616, 1'b1);
    wait_done(3, "t4a");
    exp_q.push_back({1'b1, 1'b0, 12'h000});
    do_start(12'h948, 12'h051, 1'b1);
    check("t4_b2b_busy", {31'd0, busy}, 32'd1);
    wait_done(3, "t4b");
    @(negedge clk);

    // A start pulsed mid-RUN must be ignored
    exp_q.push_back({1'b1, 1'b0, 12'h517});
    do_start(12'h682, 12'h835, 1'b0);
    A = 12'h111;
    B = 12'h222;
    cin = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(2, "t5_ignore");
    @(negedge clk);

    // Reset while RUN is at idx=1
    do_start(12'h999, 12'h999, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", {31'd0, ready}, 32'd1);
    check("abort_busy",  {31'd0, busy},  32'd0);
    check("abort_S",     {20'd0, S},     32'd0);
    check("abort_cout",  {31'd0, cout},  32'd0);
    check("abort_err",   {31'd0, err},   32'd0);
    for (int i = 0; i < 4; i++) begin
      check("abort_no_done", {31'd0, done}, 32'd0);
      @(negedge clk);
    end

    // Invalid digits: A=A85 + B=556.
    // Digit0: 5+6=11 -> 1, carry 1. Digit1: 8+5+1=14 -> 4, carry 1.
    // Digit2: A+5+1=16 -> 6, carry 1. Result S=641, cout=1, err=1.
    exp_q.push_back({1'b1, 1'b1, 12'h641});
    do_start(12'hA85, 12'h556, 1'b0);
    wait_done(3, "t6");
    @(negedge clk);

    // Random valid operands; the first one also shows err clearing
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < 3; i++) begin
        ra[i*4 +: 4] = 4'($urandom_range(0, 9));
        rb[i*4 +: 4] = 4'($urandom_range(0, 9));
      end
      rc = 1'($urandom_range(0, 1));
      exp_q.push_back(model3(ra, rb, rc));
      do_start(ra, rb, rc);
      wait_done(3, "rand");
      @(negedge clk);
    end

    // DIGITS=1: 7 + 5 = 12 -> S=2, cout=1, done one cycle after accept
    exp1_q.push_back({1'b1, 1'b0, 4'h2});
    A1 = 4'h7;
    B1 = 4'h5;
    cin1 = 1'b0;
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    begin
      int n;
      n = 0;
      while (done1 !== 1'b1 && n < 20) begin
        @(negedge clk);
        n++;
      end
      check("d1_latency", n, 1);
    end
    @(negedge clk);
    check("d1_done_pulse", {31'd0, done1}, 32'd0);

    repeat (3) @(negedge clk);
    check("exp_q_drained",  exp_q.size(),  0);
    check("exp1_q_drained", exp1_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
